// File: rtl/audio_pkg.sv
// Shared definitions for the audio sample path: sample width/type and filter defaults.
package audio_pkg;

    localparam int SAMPLE_W = 24;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam int FILTER_LOG2_N = 3;

endpackage : audio_pkg

// File: rtl/sample_fifo.sv
// Circular window of the last 2^DEPTH_LOG2 samples with a saturating fill count.
// Reading the oldest entry and overwriting that slot happen in the same cycle; the read sees the old value.
module sample_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] oldest,
    output logic             full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2:0]   count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            count <= '0;
        end else if (push) begin
            wptr <= wptr + 1'b1;
            if (!full) begin
                count <= count + 1'b1;
            end
        end
    end

    // Storage is never cleared: stale entries are masked until count reaches DEPTH.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    assign full   = (count == DEPTH_CNT);
    assign oldest = full ? mem[wptr] : '0;

endmodule : sample_fifo

// File: rtl/moving_average_filter.sv
// N-tap boxcar filter: pre-scales each sample by 1/N and keeps a running sum over the last N.
// in_valid is a one-cycle strobe with no backpressure; out_valid pulses once per accepted sample, one edge later.
module moving_average_filter
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = SAMPLE_W,
    parameter int LOG2_N     = FILTER_LOG2_N
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    output logic                         primed
);

    logic signed [DATA_WIDTH-1:0] scaled;
    logic        [DATA_WIDTH-1:0] oldest_raw;
    logic signed [DATA_WIDTH-1:0] oldest;
    logic signed [DATA_WIDTH-1:0] acc;
    logic                         fifo_full;

    // Arithmetic shift rounds toward minus infinity, so -1 stays -1.
    assign scaled = in_data >>> LOG2_N;
    assign oldest = oldest_raw;

    sample_fifo #(
        .DEPTH_LOG2 (LOG2_N),
        .WIDTH      (DATA_WIDTH)
    ) u_window (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (in_valid),
        .din     (scaled),
        .oldest  (oldest_raw),
        .full    (fifo_full)
    );

    // Each term is bounded by 2^(W-1)/N, so the N-term sum fits in W bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                acc <= acc + scaled - oldest;
            end
        end
    end

    assign out_data = acc;
    assign primed   = fifo_full;

endmodule : moving_average_filter

// File: tb/tb_moving_average_filter.sv
// Directed bench for moving_average_filter with an expected-value queue and a final report.
module tb_moving_average_filter;

    localparam int W = 24;

    logic                clk;
    logic                reset_n;
    logic                in_valid;
    logic signed [W-1:0] in_data;
    logic signed [W-1:0] out_data;
    logic                out_valid;
    logic                primed;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] act_q[$];
    logic [W-1:0] b2b_q[$];
    logic [W-1:0] rnd [16];

    int n_checks = 0;
    int n_pass   = 0;

    moving_average_filter #(.DATA_WIDTH(W), .LOG2_N(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .primed    (primed)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, need finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h need %h at %0t", tag, got, exp, $time);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        act_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    // One strobe; output is sampled #1 after the accepting edge and scored against exp_q.
    task automatic send(input logic [W-1:0] d);
        logic [W-1:0] e;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("out_valid_pulse", W'(out_valid), W'(1));
        if (exp_q.size() == 0) begin
            check("exp_q_underflow", W'(exp_q.size()), W'(1));
        end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e);
        end
        act_q.push_back(out_data);
    endtask

    task automatic idle(input int n, input logic [W-1:0] hold);
        repeat (n) begin
            @(posedge clk);
            #1;
            check("gap_valid_low", W'(out_valid), W'(0));
            check("gap_hold", out_data, hold);
        end
    endtask

    // Direct window sum of the last 8 pre-scaled samples ending at index i.
    function automatic logic [W-1:0] window_sum(input int i);
        int sum = 0;
        int lo;
        int sv;
        lo = (i >= 7) ? i - 7 : 0;
        for (int j = lo; j <= i; j++) begin
            sv  = int'($signed(rnd[j]));
            sum = sum + (sv >>> 3);
        end
        return W'(sum);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] hold_v;
        int gap;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_data", out_data, W'(0));
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_primed", W'(primed), W'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // Constant 800: ramp 100..800 then steady; primed with the 8th output.
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(W'((i < 8 ? i + 1 : 8) * 100));
            send(W'(800));
            check("const_primed", W'(primed), W'(i >= 7));
        end

        // Impulse: 1000 for eight outputs, then the oldest is subtracted away.
        do_reset();
        for (int i = 0; i < 11; i++) exp_q.push_back(i < 8 ? W'(1000) : W'(0));
        send(W'(8000));
        for (int i = 0; i < 10; i++) send(W'(0));

        // Negative and truncation cases.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(W'(-(i + 1)));
            send(W'(-8));
        end
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(W'(0));
            send(W'(7));
        end
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(W'(-(i + 1)));
            send(W'(-1));
        end

        // Same random sequence back-to-back, then with gaps.
        for (int i = 0; i < 16; i++) rnd[i] = W'($urandom_range(0, 32'hFFFFFF));
        do_reset();
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(window_sum(i));
            send(rnd[i]);
        end
        b2b_q = act_q;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(window_sum(i));
            send(rnd[i]);
            gap = $urandom_range(1, 3);
            hold_v = window_sum(i);
            idle(gap, hold_v);
        end
        check("gap_count", W'(act_q.size()), W'(16));
        for (int i = 0; i < 16 && i < act_q.size() && i < b2b_q.size(); i++)
            check("gap_vs_b2b", act_q[i], b2b_q[i]);

        // Asynchronous reset mid-stream, away from a clock edge.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(W'((i + 1) * 100));
            send(W'(800));
        end
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_out_data", out_data, W'(0));
        check("async_rst_primed", W'(primed), W'(0));
        check("async_rst_valid", W'(out_valid), W'(0));
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(W'((i < 8 ? i + 1 : 8) * 10));
            send(W'(80));
        end

        // Full-scale positive then negative; every step must be exact (no wrap).
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            exp_q.push_back(W'((k < 8 ? k : 8) * 1048575));
            send(24'h7FFFFF);
        end
        check("pos_full_scale", out_data, 24'h7FFFF8);
        for (int k = 1; k <= 20; k++) begin
            gap = (k < 8) ? k : 8;
            exp_q.push_back(W'((8 - gap) * 1048575 - gap * 1048576));
            send(24'h800000);
        end
        check("neg_full_scale", out_data, 24'h800000);
        check("exp_q_drained", W'(exp_q.size()), W'(0));

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_moving_average_filter
